// File: rtl/conv_output_stage.sv
`default_nettype none
// ============================================================================
// conv_output_stage : bias add, activation, saturation, vector FIFO and
//                     one-channel-per-beat serializer for the adder array.
// Revision 1.0
// ============================================================================
module conv_output_stage #(
   parameter int DATA_WIDTH = 14,
   parameter int NUM_CH     = 16,
   parameter int FRAC_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_valids,
   output logic                         in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] bias,
   input  logic [1:0]                   act_mode,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(NUM_CH)-1:0]    out_channel,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         overrun,
   output logic                         protocol_err
);
   localparam int VW = NUM_CH * DATA_WIDTH;
   localparam int CW = $clog2(NUM_CH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int MW = 2 * DATA_WIDTH + FRAC_BITS + 20;
   localparam logic signed [MW-1:0] C_MAX   = MW'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [MW-1:0] C_MIN   = MW'(-(2 ** (DATA_WIDTH - 1)));
   localparam logic signed [MW-1:0] C_THREE = MW'(3 << FRAC_BITS);
   localparam logic signed [MW-1:0] C_SIX   = MW'(6 << FRAC_BITS);
   localparam logic signed [MW-1:0] C_HS    = MW'(10923);
   localparam logic [CW-1:0]        LAST_CH = CW'(NUM_CH - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

   logic          all_valid, any_valid, accept;
   logic [VW-1:0] biased, activated;
   logic          s1_valid_q, s2_valid_q;
   logic [VW-1:0] s1_data_q, s2_data_q;
   logic [1:0]    s1_mode_q;
   logic [VW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q, count;
   logic [PW:0]   occupancy;
   logic          push, pop;
   state_t        state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [VW-1:0] head;
   logic          overrun_q, protocol_err_q;

   assign all_valid = &in_valids;
   assign any_valid = |in_valids;
   assign accept    = all_valid & in_ready;

   // Sign-extend to DATA_WIDTH+1, add, clamp on overflow of the extra bit.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_bias
      logic [DATA_WIDTH-1:0] a, b;
      logic [DATA_WIDTH:0]   sum;
      assign a   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign b   = bias[i*DATA_WIDTH +: DATA_WIDTH];
      assign sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      assign biased[i*DATA_WIDTH +: DATA_WIDTH] = (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) ?
             {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}} : sum[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_data_q <= biased;
            s1_mode_q <= act_mode;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_act
      logic signed [DATA_WIDTH-1:0] s;
      logic signed [MW-1:0]         s_ext, t, c, prod, shr;
      logic [DATA_WIDTH-1:0]        relu, hs;
      assign s     = s1_data_q[i*DATA_WIDTH +: DATA_WIDTH];
      assign s_ext = MW'(s);
      assign t     = s_ext + C_THREE;
      assign c     = (t < 0) ? '0 : ((t > C_SIX) ? C_SIX : t);
      assign prod  = s_ext * c * C_HS;
      assign shr   = prod >>> (FRAC_BITS + 16);
      assign hs    = (shr > C_MAX) ? C_MAX[DATA_WIDTH-1:0] :
                     (shr < C_MIN) ? C_MIN[DATA_WIDTH-1:0] : shr[DATA_WIDTH-1:0];
      assign relu  = s[DATA_WIDTH-1] ? '0 : s;
      assign activated[i*DATA_WIDTH +: DATA_WIDTH] = (s1_mode_q == 2'd1) ? relu :
                                                     (s1_mode_q == 2'd2) ? hs : s;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) s2_data_q <= activated;
      end
   end

   // Vector FIFO; in_ready reserves space for everything still in the pipeline.
   assign push      = s2_valid_q;
   assign pop       = (state_q == ST_SEND) & out_ready & (ch_q == LAST_CH);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign occupancy = {1'b0, count} + (PW+1)'(s1_valid_q) + (PW+1)'(s2_valid_q);
   assign in_ready  = occupancy < (PW+1)'(FIFO_DEPTH);
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= s2_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // A same-cycle FIFO write counts as non-empty so channel 0 appears at T+3.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         ST_IDLE: begin
            if (count != '0 || push) begin
               state_d = ST_SEND;
               ch_d    = '0;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               if (ch_q == LAST_CH) begin
                  ch_d = '0;
                  if (count <= PW'(1) && !push) state_d = ST_IDLE;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         ch_q           <= '0;
         overrun_q      <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         if (all_valid && !in_ready)     overrun_q      <= 1'b1;
         if (any_valid && !all_valid)    protocol_err_q <= 1'b1;
      end
   end

   assign out_valid    = (state_q == ST_SEND);
   assign out_data     = out_valid ? head[ch_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign out_channel  = out_valid ? ch_q : '0;
   assign out_last     = out_valid && (ch_q == LAST_CH);
   assign overrun      = overrun_q;
   assign protocol_err = protocol_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_output_stage.sv
`default_nettype none
// tb_conv_output_stage : directed and random stimulus against a
// transaction-level reference model of the output stage.
module tb_conv_output_stage;
   localparam int DW = 14;
   localparam int NC = 16;
   localparam int FB = 8;
   localparam int FD = 4;
   localparam int VMAX = (1 << (DW - 1)) - 1;
   localparam int VMIN = -(1 << (DW - 1));

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NC*DW-1:0]  in_data = '0;
   logic [NC*DW-1:0]  bias = '0;
   logic [NC-1:0]     in_valids = '0;
   logic              in_ready;
   logic [1:0]        act_mode = '0;
   logic [DW-1:0]     out_data;
   logic [3:0]        out_channel;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_last;
   logic              overrun;
   logic              protocol_err;

   conv_output_stage #(
      .DATA_WIDTH(DW), .NUM_CH(NC), .FRAC_BITS(FB), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valids(in_valids),
      .in_ready(in_ready), .bias(bias), .act_mode(act_mode), .out_data(out_data),
      .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .overrun(overrun), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          qv[$];          // expected outputs, NC per accepted vector
   int          qr[$];          // cycle from which each vector may be output
   int          mch = 0;
   bit          m_ovr = 1'b0;
   bit          m_perr = 1'b0;
   int          n_acc = 0;
   int          v_data[NC];
   int          v_bias[NC];
   logic [NC-1:0] v_valids = '0;
   logic [1:0]  v_mode = '0;
   logic        v_ready = 1'b0;
   int          got[NC];
   int          beats = 0;
   int          first_beat = -1;
   int          last_beat = -1;
   int          acc_cyc = 0;

   task automatic chk(input string tag, input longint got_v, input longint exp_v);
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got_v, exp_v, cyc);
      end
   endtask

   function automatic int ref_out(input int d, input int b, input int mode);
      int s;
      longint c, p, y;
      s = d + b;
      if (s > VMAX) s = VMAX;
      if (s < VMIN) s = VMIN;
      case (mode)
         1: return (s < 0) ? 0 : s;
         2: begin
            c = longint'(s) + 3 * (1 << FB);
            if (c < 0) c = 0;
            if (c > 6 * (1 << FB)) c = 6 * (1 << FB);
            p = longint'(s) * c * 10923;
            y = p >>> (FB + 16);
            if (y > VMAX) y = VMAX;
            if (y < VMIN) y = VMIN;
            return int'(y);
         end
         default: return s;
      endcase
   endfunction

   function automatic int rnd();
      logic [DW-1:0] r;
      r = DW'($urandom);
      case ($urandom_range(0, 7))
         0: return VMAX;
         1: return VMIN;
         default: return int'($signed(r));
      endcase
   endfunction

   // Check the current cycle, then drive the v_* inputs and advance the model.
   task automatic tick();
      bit mv, rdy;
      @(negedge clk);
      cyc++;
      mv  = (qr.size() > 0) && (qr[0] <= cyc);
      rdy = (qr.size() < FD);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, mv);
      chk("overrun", overrun, m_ovr);
      chk("protocol_err", protocol_err, m_perr);
      if (mv) begin
         chk("out_data", $signed(out_data), qv[mch]);
         chk("out_channel", out_channel, mch);
         chk("out_last", out_last, mch == NC - 1);
      end
      for (int i = 0; i < NC; i++) begin
         in_data[i*DW +: DW] = DW'(v_data[i]);
         bias[i*DW +: DW]    = DW'(v_bias[i]);
      end
      in_valids = v_valids;
      act_mode  = v_mode;
      out_ready = v_ready;
      if (mv && v_ready) begin
         got[mch] = int'($signed(out_data));
         beats++;
         if (first_beat < 0) first_beat = cyc;
         last_beat = cyc;
         if (mch == NC - 1) begin
            repeat (NC) void'(qv.pop_front());
            void'(qr.pop_front());
            mch = 0;
         end else begin
            mch++;
         end
      end
      if (&v_valids) begin
         if (rdy) begin
            for (int i = 0; i < NC; i++) qv.push_back(ref_out(v_data[i], v_bias[i], int'(v_mode)));
            qr.push_back(cyc + 3);
            n_acc++;
            acc_cyc = cyc;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (|v_valids) begin
         m_perr = 1'b1;
      end
   endtask

   task automatic set_rand_vec(input logic [1:0] mode);
      for (int i = 0; i < NC; i++) begin
         v_data[i] = rnd();
         v_bias[i] = ($urandom_range(0, 3) == 0) ? rnd() : int'($urandom_range(0, 200)) - 100;
      end
      v_mode = mode;
   endtask

   task automatic send();
      v_valids = '1;
      tick();
      v_valids = '0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      v_ready  = 1'b1;
      v_valids = '0;
      while (qr.size() > 0 && n < limit) begin
         tick();
         n++;
      end
      if (qr.size() > 0) chk("drain_timeout", qr.size(), 0);
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < NC; i++) begin
         v_data[i] = 0;
         v_bias[i] = 0;
      end
      #1 reset = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_channel", out_channel, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_protocol_err", protocol_err, 0);
      @(negedge clk);
      reset = 1'b1;

      // ReLU
      set_rand_vec(2'd1);
      v_data[0] = -300; v_data[1] = 0; v_data[2] = 500; v_data[3] = 8191;
      for (int i = 0; i < NC; i++) v_bias[i] = 0;
      v_ready = 1'b1;
      first_beat = -1;
      send();
      drain(100);
      chk("relu_latency", first_beat - acc_cyc, 3);
      chk("relu_span", last_beat - first_beat, NC - 1);
      chk("relu_ch0", got[0], 0);
      chk("relu_ch1", got[1], 0);
      chk("relu_ch2", got[2], 500);
      chk("relu_ch3", got[3], 8191);

      // hard-swish
      set_rand_vec(2'd2);
      v_data[0] = 256; v_data[1] = 1024; v_data[2] = -1024;
      for (int i = 0; i < NC; i++) v_bias[i] = 0;
      send();
      drain(100);
      chk("hswish_ch0", got[0], 170);
      chk("hswish_ch1", got[1], 1024);
      chk("hswish_ch2", got[2], 0);

      // saturating bias add
      set_rand_vec(2'd0);
      v_data[0] = 8191;  v_bias[0] = 1;
      v_data[1] = -8192; v_bias[1] = -1;
      send();
      drain(100);
      chk("sat_ch0", got[0], 8191);
      chk("sat_ch1", got[1], -8192);

      // back-pressure: five vectors into four slots
      v_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_rand_vec(2'($urandom_range(0, 3)));
         v_valids = '1;
         tick();
      end
      v_valids = '0;
      repeat (4) tick();
      chk("ovr_sticky", overrun, 1);
      chk("ovr_in_ready", in_ready, 0);
      beats = 0;
      first_beat = -1;
      drain(300);
      chk("ovr_beats", beats, 4 * NC);
      chk("ovr_span", last_beat - first_beat, 4 * NC - 1);

      // partial valid, then reset in the middle of a vector
      v_valids = 16'h00FF;
      tick();
      v_valids = '0;
      repeat (4) tick();
      chk("perr_sticky", protocol_err, 1);
      set_rand_vec(2'd0);
      v_ready = 1'b1;
      send();
      n = 0;
      while (mch != 7 && n < 60) begin
         tick();
         n++;
      end
      #6;
      chk("pre_rst_channel", out_channel, 7);
      chk("pre_rst_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_protocol_err", protocol_err, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      qv.delete();
      qr.delete();
      mch = 0;
      m_ovr = 1'b0;
      m_perr = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();

      // random traffic with random back-pressure
      n = 0;
      begin
         int target;
         target = n_acc + 8;
         while ((n_acc < target || qr.size() > 0) && n < 3000) begin
            v_ready = 1'($urandom_range(0, 1));
            if (n_acc < target && $urandom_range(0, 2) == 0) begin
               set_rand_vec(2'($urandom_range(0, 3)));
               v_valids = '1;
            end else begin
               v_valids = '0;
            end
            tick();
            n++;
         end
         if (n_acc < target || qr.size() > 0) chk("random_timeout", qr.size(), 0);
      end
      drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_output_stage.md
Name: conv_output_stage

Overview:
- Sits directly downstream of the 16-lane parallel adder array; consumes one vector of NUM_CH accumulated sums per accepted beat.
- Adds a per-channel bias, applies the selected activation (none / ReLU / hard-swish), saturates, buffers whole vectors in a small FIFO, and serializes them one channel per beat on a valid/ready stream toward the feature-map writer.

Parameters:
- DATA_WIDTH, 14, signed two's-complement width of sums, bias and outputs.
- NUM_CH, 16, channels per vector; matches the upstream adder count.
- FRAC_BITS, 8, fractional bits of the fixed-point format, used by hard-swish.
- FIFO_DEPTH, 4, vector entries in the output FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  NUM_CH*DATA_WIDTH  sums; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valids  in  NUM_CH  per-lane valid from the adders.
- in_ready  out  1  a vector can be accepted this cycle.
- bias  in  NUM_CH*DATA_WIDTH  per-channel bias, same packing as in_data.
- act_mode  in  2  0 = none, 1 = ReLU, 2 = hard-swish, 3 = treated as none.
- out_data  out  DATA_WIDTH  serialized result.
- out_channel  out  $clog2(NUM_CH)  channel index of out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high on the channel NUM_CH-1 beat.
- overrun  out  1  sticky: a full vector arrived while in_ready was low.
- protocol_err  out  1  sticky: in_valids was non-zero but not all ones.

Behaviour:
- Reset, asynchronous and active-low: all outputs go to 0 immediately, except in_ready, which goes to 1. FIFO, pipeline and serializer are cleared; stickies are cleared. Asserting reset mid-serialization abandons the vector; no partial beat survives.
- Accept: when &in_valids is 1 and in_ready is 1, the vector is accepted. in_data, bias and act_mode are all captured at that edge.
- Discard: when &in_valids is 1 and in_ready is 0, the vector is discarded and overrun is set.
- Partial valid: when in_valids is non-zero but not all ones, nothing is accepted and protocol_err is set.
- in_ready = (fifo_count + pipeline_occupancy) < FIFO_DEPTH, where pipeline_occupancy is the number of valid pipeline stages (0..2). in_ready is registered-consistent and does not depend on the current-cycle in_valids.
- Stage 1 (bias add): s = in + bias, computed at DATA_WIDTH+1 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Stage 2 (activation):
  - none: y = s.
  - ReLU: y = (s < 0) ? 0 : s.
  - hard-swish: c = clamp(s + (3<<FRAC_BITS), 0, 6<<FRAC_BITS); y = (s*c*10923) >>> (FRAC_BITS+16), using an arithmetic (floor) shift and full-width intermediates; result saturated to DATA_WIDTH.
- The FIFO write occurs at the end of stage 2. The pipeline never stalls; in_ready guarantees FIFO space.
- Serializer FSM:
  - IDLE: out_valid = 0. Moves to SEND when the FIFO is non-empty; channel counter = 0.
  - SEND: out_valid = 1, out_data = head[ch], out_channel = ch, out_last = (ch == NUM_CH-1).
    - On out_valid & out_ready with ch < NUM_CH-1: ch increments.
    - On the handshake with ch = NUM_CH-1: the FIFO pops. Stay in SEND with ch = 0 if another vector is present (no bubble), otherwise go to IDLE.
  - While out_valid = 1 and out_ready = 0, out_data, out_channel and out_last hold stable.
- Latency: a vector accepted in cycle T with the FIFO empty and the FSM idle gives out_valid = 1 for channel 0 in cycle T+3. Steady-state throughput is 1 channel per cycle.
- Simultaneous FIFO write and pop in the same cycle: both happen and the count is unchanged. The full condition never coincides with a write, by construction of in_ready.
- fifo_count wraps via pointers of width $clog2(FIFO_DEPTH)+1.

Test Plan:
- act_mode=1, in_data ch0..3 = {-300, 0, 500, 8191}, bias = 0 → out_data = {0, 0, 500, 8191}; first beat at T+3; out_last only on ch15.
- act_mode=2, ch0..2 = {256, 1024, -1024} (1.0, 4.0, -4.0), bias = 0 → {170, 1024, 0}.
- act_mode=0, ch0 = 8191 with bias 1, ch1 = -8192 with bias -1 → ch0 = 8191, ch1 = -8192 (saturated).
- out_ready = 0; push 5 back-to-back vectors → in_ready falls after the 4th accept, the 5th is dropped, overrun = 1. Release out_ready → exactly 64 beats, with data of vectors 1-4 in order and no bubble between vectors.
- in_valids = 16'h00FF for 1 cycle → protocol_err = 1, no output beat. Then apply reset low mid-SEND (ch = 7) → out_valid = 0 and stickies = 0 immediately, in_ready = 1.
- Random out_ready toggling over 8 vectors → out_data, out_channel and out_last stay stable while stalled; the scoreboard matches the reference model bit-exact.
